// File: rtl/tl_pkg.sv
// Shared definitions for the intersection model.
// Holds the controller's light codes, the lane index constants used to
// address the per-lane vectors (dep, lane arrays), and the helper that
// decides whether a light change is a legal step of the controller cycle.
package tl_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] LEFT   = 2'b10;
  localparam logic [1:0] RED    = 2'b11;

  localparam int LANE_A  = 0;
  localparam int LANE_AL = 1;
  localparam int LANE_B  = 2;
  localparam int LANE_BL = 3;

  // Holding a code is always fine; otherwise only the controller's own
  // successor steps are accepted.
  function automatic logic seq_legal(input logic [1:0] prev_code,
                                     input logic [1:0] cur_code);
    logic ok;
    ok = 1'b0;
    if (prev_code == cur_code) begin
      ok = 1'b1;
    end else begin
      case (prev_code)
        GREEN:   ok = (cur_code == YELLOW);
        YELLOW:  ok = (cur_code == LEFT) || (cur_code == RED);
        LEFT:    ok = (cur_code == YELLOW);
        RED:     ok = (cur_code == GREEN);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/tl_lane_queue.sv
// One traffic lane: saturating car counter, departure pacing timer,
// sensor decode, departure pulse and sticky overflow.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   en_i          : lane has a go light this cycle
//   arr_i         : one-cycle car arrival pulse
//   q_o           : registered queue occupancy
//   t_o           : sensor, high while the registered count is non-zero
//   dep_o         : one-cycle pulse in the cycle after a car leaves
//   ovf_o         : sticky, an arrival was dropped because the queue was full
module tl_lane_queue
  import tl_pkg::*;
#(
  parameter int QW           = 4,
  parameter int DEP_INTERVAL = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en_i,
  input  logic          arr_i,
  output logic [QW-1:0] q_o,
  output logic          t_o,
  output logic          dep_o,
  output logic          ovf_o
);

  localparam int TW = (DEP_INTERVAL > 1) ? $clog2(DEP_INTERVAL) : 1;
  localparam logic [TW-1:0] TMAX   = TW'(DEP_INTERVAL - 1);
  localparam logic [QW-1:0] Q_FULL = {QW{1'b1}};
  localparam logic [QW-1:0] Q_ZERO = {QW{1'b0}};

  logic [QW-1:0] q_q, q_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dep_q, dep_d;
  logic          ovf_q, ovf_d;
  logic          busy_s;
  logic          fire_s;

  // Next-state for count, pacing timer, departure pulse and overflow flag.
  always_comb begin
    busy_s  = en_i && (q_q != Q_ZERO);
    fire_s  = busy_s && (timer_q == TMAX);
    q_d     = q_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    dep_d   = fire_s;

    // Arrival and departure together cancel; a lone arrival at full is dropped.
    if (arr_i && !fire_s) begin
      if (q_q == Q_FULL) begin
        ovf_d = 1'b1;
      end else begin
        q_d = q_q + {{(QW-1){1'b0}}, 1'b1};
      end
    end else if (fire_s && !arr_i) begin
      q_d = q_q - {{(QW-1){1'b0}}, 1'b1};
    end else begin
      q_d = q_q;
    end

    // A partial count is discarded as soon as the lane stops being served.
    if (!busy_s || fire_s) begin
      timer_d = {TW{1'b0}};
    end else begin
      timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q     <= Q_ZERO;
      timer_q <= {TW{1'b0}};
      dep_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      timer_q <= timer_d;
      dep_q   <= dep_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q_o   = q_q;
  assign t_o   = (q_q != Q_ZERO);
  assign dep_o = dep_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/tl_intersection_model.sv
// Closed-loop intersection model: consumes the controller's light codes,
// drives the four traffic sensors from per-lane car queues, and flags
// conflicting greens and out-of-order light changes.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   La, Lb                       : light codes for direction A and B
//   arr_a/arr_al/arr_b/arr_bl    : car arrival pulses per lane
//   Ta/Tal/Tb/Tbl                : sensors, 1 = car waiting
//   q_a/q_al/q_b/q_bl            : queue occupancy per lane
//   dep                          : departure pulses {bl, b, al, a}
//   ovf, conflict, seq_err       : sticky error flags, cleared only by reset
module tl_intersection_model
  import tl_pkg::*;
#(
  parameter int QW           = 4,
  parameter int DEP_INTERVAL = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  input  logic          arr_a,
  input  logic          arr_al,
  input  logic          arr_b,
  input  logic          arr_bl,
  output logic          Ta,
  output logic          Tal,
  output logic          Tb,
  output logic          Tbl,
  output logic [QW-1:0] q_a,
  output logic [QW-1:0] q_al,
  output logic [QW-1:0] q_b,
  output logic [QW-1:0] q_bl,
  output logic [3:0]    dep,
  output logic          ovf,
  output logic          conflict,
  output logic          seq_err
);

  logic [3:0]    en_s;
  logic [3:0]    arr_s;
  logic [3:0]    t_s;
  logic [3:0]    ovf_s;
  logic [QW-1:0] q_s [4];

  logic [1:0] prev_la_q, prev_la_d;
  logic [1:0] prev_lb_q, prev_lb_d;
  logic       conflict_q, conflict_d;
  logic       seq_err_q, seq_err_d;

  // Lane enables decoded straight from the light codes.
  always_comb begin
    en_s          = 4'b0000;
    en_s[LANE_A]  = (La == GREEN);
    en_s[LANE_AL] = (La == LEFT);
    en_s[LANE_B]  = (Lb == GREEN);
    en_s[LANE_BL] = (Lb == LEFT);
  end

  assign arr_s = {arr_bl, arr_b, arr_al, arr_a};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    tl_lane_queue #(
      .QW           (QW),
      .DEP_INTERVAL (DEP_INTERVAL)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (en_s[i]),
      .arr_i   (arr_s[i]),
      .q_o     (q_s[i]),
      .t_o     (t_s[i]),
      .dep_o   (dep[i]),
      .ovf_o   (ovf_s[i])
    );
  end

  // Safety checker: sticky conflict and sequence flags, previous light codes.
  always_comb begin
    prev_la_d  = La;
    prev_lb_d  = Lb;
    conflict_d = conflict_q;
    seq_err_d  = seq_err_q;
    if ((La != RED) && (Lb != RED)) begin
      conflict_d = 1'b1;
    end else begin
      conflict_d = conflict_q;
    end
    if (!seq_legal(prev_la_q, La) || !seq_legal(prev_lb_q, Lb)) begin
      seq_err_d = 1'b1;
    end else begin
      seq_err_d = seq_err_q;
    end
  end

  // Checker registers; previous codes start at RED so the first A-green is legal.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_la_q  <= RED;
      prev_lb_q  <= RED;
      conflict_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      prev_la_q  <= prev_la_d;
      prev_lb_q  <= prev_lb_d;
      conflict_q <= conflict_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign q_a      = q_s[LANE_A];
  assign q_al     = q_s[LANE_AL];
  assign q_b      = q_s[LANE_B];
  assign q_bl     = q_s[LANE_BL];
  assign Ta       = t_s[LANE_A];
  assign Tal      = t_s[LANE_AL];
  assign Tb       = t_s[LANE_B];
  assign Tbl      = t_s[LANE_BL];
  assign ovf      = |ovf_s;
  assign conflict = conflict_q;
  assign seq_err  = seq_err_q;

endmodule
